// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Producer-side front end for the register file's single write port. Merges
// single-cycle ALU results with variable-latency memory load results (held in
// a small FIFO) into at most one registered register-file write per cycle.
//
// Ports
//   clk_i          clock, all state updates on the rising edge
//   rst_ni         asynchronous active-low reset
//   flush_i        synchronous flush of buffered loads and the pending write
//   alu_valid_i    ALU result valid
//   alu_ready_o    ALU result accepted when alu_valid_i && alu_ready_o
//   alu_dest_i     ALU destination register
//   alu_data_i     ALU result data
//   mem_valid_i    memory load result valid
//   mem_ready_o    FIFO can accept a load result
//   mem_dest_i     load destination register
//   mem_data_i     load data
//   rf_load_o      register file write enable (registered)
//   rf_dest_o      register file write index (registered, holds when idle)
//   rf_in_o        register file write data (registered, holds when idle)
//   fifo_count_o   current load FIFO occupancy
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     alu_valid_i,
  output logic                     alu_ready_o,
  input  logic [AW-1:0]            alu_dest_i,
  input  logic [WIDTH-1:0]         alu_data_i,
  input  logic                     mem_valid_i,
  output logic                     mem_ready_o,
  input  logic [AW-1:0]            mem_dest_i,
  input  logic [WIDTH-1:0]         mem_data_i,
  output logic                     rf_load_o,
  output logic [AW-1:0]            rf_dest_o,
  output logic [WIDTH-1:0]         rf_in_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

  // Load FIFO storage
  logic [AW-1:0]    dest_mem_q [DEPTH];
  logic [WIDTH-1:0] data_mem_q [DEPTH];

  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  grant_e           last_grant_q, last_grant_d;
  logic             rf_load_q, rf_load_d;
  logic [AW-1:0]    rf_dest_q, rf_dest_d;
  logic [WIDTH-1:0] rf_in_q, rf_in_d;

  logic             empty, full, mem_pri, enq;
  logic             grant_mem, grant_alu, write_en;
  logic [AW-1:0]    grant_dest;
  logic [WIDTH-1:0] grant_data;

  assign empty = (count_q == '0);
  // Full looks at current occupancy only, so a dequeue this cycle does not
  // open a slot for a same-cycle enqueue.
  assign full  = (count_q == CW'(DEPTH));

  // Memory gets priority when it is its turn or when the FIFO is full.
  assign mem_pri = !empty && (full || (last_grant_q == GRANT_ALU));

  // Readies are gated by rst_ni so they drop to 0 immediately on reset.
  assign mem_ready_o = !full && !flush_i && rst_ni;
  assign alu_ready_o = !mem_pri && !flush_i && rst_ni;

  assign enq       = mem_valid_i && mem_ready_o;
  assign grant_mem = !flush_i && !empty && (mem_pri || !alu_valid_i);
  assign grant_alu = !flush_i && !mem_pri && alu_valid_i;

  assign grant_dest = grant_mem ? dest_mem_q[head_q] : alu_dest_i;
  assign grant_data = grant_mem ? data_mem_q[head_q] : alu_data_i;

  // Writes to x0 are consumed but never reach the register file.
  assign write_en = (grant_mem || grant_alu) && (grant_dest != '0);

  // Next-state logic
  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    rf_load_d    = 1'b0;
    rf_dest_d    = rf_dest_q;
    rf_in_d      = rf_in_q;

    if (flush_i) begin
      head_d       = '0;
      tail_d       = '0;
      count_d      = '0;
      last_grant_d = GRANT_MEM;
    end else begin
      // Pointers are PW bits wide, so they wrap modulo DEPTH naturally.
      if (enq)       tail_d = tail_q + PW'(1);
      if (grant_mem) head_d = head_q + PW'(1);
      count_d = count_q + CW'(enq) - CW'(grant_mem);

      if (grant_mem)      last_grant_d = GRANT_MEM;
      else if (grant_alu) last_grant_d = GRANT_ALU;

      rf_load_d = write_en;
      if (write_en) begin
        rf_dest_d = grant_dest;
        rf_in_d   = grant_data;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      last_grant_q <= GRANT_MEM;
      rf_load_q    <= 1'b0;
      rf_dest_q    <= '0;
      rf_in_q      <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      rf_load_q    <= rf_load_d;
      rf_dest_q    <= rf_dest_d;
      rf_in_q      <= rf_in_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      dest_mem_q[tail_q] <= mem_dest_i;
      data_mem_q[tail_q] <= mem_data_i;
    end
  end

  assign rf_load_o    = rf_load_q;
  assign rf_dest_o    = rf_dest_q;
  assign rf_in_o      = rf_in_q;
  assign fifo_count_o = count_q;

endmodule
